// File: rtl/dsp58_result_collector_pkg.sv
// Shared definitions for the DSP58 result collector.
// Holds the default frame geometry, the collector state encoding and a
// helper that sizes the beat index so a single-chain build still gets a
// legal one-bit counter.
package dsp58_result_collector_pkg;

  localparam int DEF_NUM_CASCADE_CHAINS = 32;
  localparam int DEF_OUTPUT_DATA_WIDTH  = 58;
  localparam int DEF_OUT_WIDTH          = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int beat_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsp58_result_collector_if.sv
// Bundle of the collector's frame-capture, AXI4-Stream and error signals.
//   y_valid / y_data_in / capture_ready : frame capture strobe, data, ready
//   m_axis_tdata/tvalid/tready/tlast    : output stream
//   overflow_err / sat_err / clear_err  : sticky error flags and their clear
// Modport 'slave' is the collector itself; 'master' is the surrounding logic
// that produces frames and sinks the stream.
interface dsp58_result_collector_if
  import dsp58_result_collector_pkg::*;
#(
  parameter int NUM_CASCADE_CHAINS = DEF_NUM_CASCADE_CHAINS,
  parameter int OUTPUT_DATA_WIDTH  = DEF_OUTPUT_DATA_WIDTH,
  parameter int OUT_WIDTH          = DEF_OUT_WIDTH
);

  logic                                y_valid;
  logic signed [OUTPUT_DATA_WIDTH-1:0] y_data_in [NUM_CASCADE_CHAINS];
  logic                                capture_ready;
  logic [OUT_WIDTH-1:0]                m_axis_tdata;
  logic                                m_axis_tvalid;
  logic                                m_axis_tready;
  logic                                m_axis_tlast;
  logic                                overflow_err;
  logic                                sat_err;
  logic                                clear_err;

  modport master (
    output y_valid, y_data_in, m_axis_tready, clear_err,
    input  capture_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           overflow_err, sat_err
  );

  modport slave (
    input  y_valid, y_data_in, m_axis_tready, clear_err,
    output capture_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           overflow_err, sat_err
  );

endinterface

// File: rtl/dsp58_round_sat.sv
// Combinational round / arithmetic-shift / saturate of one chain result.
//   i_data : signed IN_WIDTH chain result
//   o_data : OUT_WIDTH two's-complement result, clamped to the signed range
//   o_sat  : high when o_data was clamped
// Rounding adds half an LSB of the shifted result (round half toward +inf).
// Everything runs one bit wider than the input so the rounding add cannot wrap.
module dsp58_round_sat #(
  parameter int IN_WIDTH  = 58,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 0
) (
  input  logic signed [IN_WIDTH-1:0] i_data,
  output logic [OUT_WIDTH-1:0]       o_data,
  output logic                       o_sat
);

  localparam int EW = IN_WIDTH + 1;

  localparam logic signed [EW-1:0] MAX_VAL =
    {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_VAL =
    {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_rnd;
  logic signed [EW-1:0] w_shf;

  assign w_ext = {i_data[IN_WIDTH-1], i_data};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
      assign w_rnd = w_ext + HALF;
    end else begin : g_pass
      assign w_rnd = w_ext;
    end
  endgenerate

  assign w_shf = w_rnd >>> SHIFT;

  always_comb begin
    o_sat  = 1'b0;
    o_data = w_shf[OUT_WIDTH-1:0];
    if (w_shf > MAX_VAL) begin
      o_sat  = 1'b1;
      o_data = MAX_VAL[OUT_WIDTH-1:0];
    end else if (w_shf < MIN_VAL) begin
      o_sat  = 1'b1;
      o_data = MIN_VAL[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dsp58_result_collector.sv
// Captures a frame of NUM_CASCADE_CHAINS DSP58 cascade results on a one-cycle
// strobe and streams them out over AXI4-Stream, chain 0 first, each word
// rounded/shifted/saturated to OUT_WIDTH.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : capture, stream and error-flag signals (slave side)
//
// state  | meaning
// IDLE   | no frame held, capture_ready=1, stream idle
// STREAM | frame in shadow bank, beats being presented
//
// The word for the next beat is pre-computed through one round/sat unit and
// registered, so tdata never sees a combinational path from the bank.  The
// unit's input is the incoming chain 0 on an accepted strobe, otherwise the
// bank entry after the current beat.
module dsp58_result_collector
  import dsp58_result_collector_pkg::*;
#(
  parameter int NUM_CASCADE_CHAINS = DEF_NUM_CASCADE_CHAINS,
  parameter int OUTPUT_DATA_WIDTH  = DEF_OUTPUT_DATA_WIDTH,
  parameter int OUT_WIDTH          = DEF_OUT_WIDTH,
  parameter int SHIFT              = 0
) (
  input logic                     clk,
  input logic                     rst,
  dsp58_result_collector_if.slave bus
);

  localparam int BW = beat_idx_width(NUM_CASCADE_CHAINS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_CASCADE_CHAINS - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [BW-1:0]                 r_beat;
  logic signed [OUTPUT_DATA_WIDTH-1:0] r_bank [NUM_CASCADE_CHAINS];
  logic [OUT_WIDTH-1:0]          r_tdata;
  logic                          r_tvalid;
  logic                          r_tlast;
  logic                          r_beat_sat;
  logic                          r_ovf;
  logic                          r_sat;

  logic                          w_hs;
  logic                          w_last_hs;
  logic                          w_advance;
  logic                          w_capture_ready;
  logic                          w_accept;
  logic [BW-1:0]                 w_beat_nxt;
  logic signed [OUTPUT_DATA_WIDTH-1:0] w_sel_word;
  logic [OUT_WIDTH-1:0]          w_rs_data;
  logic                          w_rs_sat;

  assign w_hs       = r_tvalid & bus.m_axis_tready;
  assign w_last_hs  = w_hs & r_tlast;
  assign w_advance  = w_hs & ~r_tlast;
  assign w_accept   = bus.y_valid & w_capture_ready;
  assign w_beat_nxt = r_beat + BW'(1);
  assign w_sel_word = w_accept ? bus.y_data_in[0] : r_bank[w_beat_nxt];

  dsp58_round_sat #(
    .IN_WIDTH  (OUTPUT_DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_round_sat (
    .i_data (w_sel_word),
    .o_data (w_rs_data),
    .o_sat  (w_rs_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = STREAM;
      STREAM:  if (w_last_hs && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_capture_ready = 1'b0;
    case (r_state)
      IDLE:    w_capture_ready = 1'b1;
      STREAM:  w_capture_ready = w_last_hs;
      default: w_capture_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat     <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_beat_sat <= 1'b0;
    end else if (w_accept) begin
      r_beat     <= '0;
      r_tdata    <= w_rs_data;
      r_tvalid   <= 1'b1;
      r_tlast    <= (NUM_CASCADE_CHAINS == 1);
      r_beat_sat <= w_rs_sat;
    end else if (w_advance) begin
      r_beat     <= w_beat_nxt;
      r_tdata    <= w_rs_data;
      r_tlast    <= (w_beat_nxt == LAST_BEAT);
      r_beat_sat <= w_rs_sat;
    end else if (w_last_hs) begin
      r_beat     <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
    end
  end

  // Bank is only ever read after a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NUM_CASCADE_CHAINS; i++) begin
        r_bank[i] <= bus.y_data_in[i];
      end
    end
  end

  // Set terms are OR-ed in after the clear so a coincident event wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_ovf <= (bus.y_valid & ~w_capture_ready) | (r_ovf & ~bus.clear_err);
      r_sat <= (w_hs & r_beat_sat) | (r_sat & ~bus.clear_err);
    end
  end

  assign bus.capture_ready = w_capture_ready;
  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tvalid = r_tvalid;
  assign bus.m_axis_tlast  = r_tlast;
  assign bus.overflow_err  = r_ovf;
  assign bus.sat_err       = r_sat;

endmodule

// File: tb/tb_dsp58_result_collector.sv
// Bench for dsp58_result_collector: two instances (SHIFT=0 and SHIFT=4) share
// identical stimulus. A negedge monitor holds a queue of expected beats built
// from the arithmetic definition of rounding/saturation and checks every
// cycle; directed scenario tasks add their own inline checks.
module tb_dsp58_result_collector;
  import dsp58_result_collector_pkg::*;

  localparam int N  = 32;
  localparam int DW = 58;
  localparam int OW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic y_valid = 1'b0;
  logic tready = 1'b1;
  logic clear_err = 1'b0;
  logic signed [DW-1:0] y_data [N];

  always #5 clk = ~clk;

  dsp58_result_collector_if #(.NUM_CASCADE_CHAINS(N), .OUTPUT_DATA_WIDTH(DW), .OUT_WIDTH(OW)) if0 ();
  dsp58_result_collector_if #(.NUM_CASCADE_CHAINS(N), .OUTPUT_DATA_WIDTH(DW), .OUT_WIDTH(OW)) if4 ();

  assign if0.y_valid = y_valid;
  assign if4.y_valid = y_valid;
  assign if0.m_axis_tready = tready;
  assign if4.m_axis_tready = tready;
  assign if0.clear_err = clear_err;
  assign if4.clear_err = clear_err;
  for (genvar k = 0; k < N; k++) begin : g_y
    assign if0.y_data_in[k] = y_data[k];
    assign if4.y_data_in[k] = y_data[k];
  end

  dsp58_result_collector #(.NUM_CASCADE_CHAINS(N), .OUTPUT_DATA_WIDTH(DW), .OUT_WIDTH(OW), .SHIFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  dsp58_result_collector #(.NUM_CASCADE_CHAINS(N), .OUTPUT_DATA_WIDTH(DW), .OUT_WIDTH(OW), .SHIFT(4))
    dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic [31:0] w_tdata [2];
  logic w_tvalid [2], w_tlast [2], w_rdy [2], w_ovf [2], w_sat [2];
  assign w_tdata[0] = if0.m_axis_tdata;   assign w_tdata[1] = if4.m_axis_tdata;
  assign w_tvalid[0] = if0.m_axis_tvalid; assign w_tvalid[1] = if4.m_axis_tvalid;
  assign w_tlast[0] = if0.m_axis_tlast;   assign w_tlast[1] = if4.m_axis_tlast;
  assign w_rdy[0] = if0.capture_ready;    assign w_rdy[1] = if4.capture_ready;
  assign w_ovf[0] = if0.overflow_err;     assign w_ovf[1] = if4.overflow_err;
  assign w_sat[0] = if0.sat_err;          assign w_sat[1] = if4.sat_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d4;
    bit s0;
    bit s4;
    bit last;
  } beat_t;

  beat_t q[$];
  bit m_ovf = 0, m_sat0 = 0, m_sat4 = 0;

  // Reference scaling: floor((v + 2^(s-1)) / 2^s), then clamp to 32-bit signed.
  function automatic logic [31:0] ref_word(input longint v, input int s, output bit sat);
    longint r;
    r = v;
    if (s > 0) r = (v + (longint'(1) << (s - 1))) >>> s;
    sat = 1'b0;
    if (r > 64'sd2147483647) begin
      sat = 1'b1;
      r = 64'sd2147483647;
    end else if (r < -64'sd2147483648) begin
      sat = 1'b1;
      r = -64'sd2147483648;
    end
    return r[31:0];
  endfunction

  always @(negedge clk) begin
    beat_t f;
    beat_t b;
    bit ev, er, hs, s0, s4, ss0, ss4;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_sat0 = 0; m_sat4 = 0;
    end else begin
      ev = (q.size() != 0);
      er = !ev || (q.size() == 1 && tready);
      f = ev ? q[0] : '{default: 0};
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (w_tvalid[d] !== ev || w_rdy[d] !== er || w_ovf[d] !== m_ovf ||
            w_sat[d] !== (d == 1 ? m_sat4 : m_sat0)) begin
          n_err++;
          $display("FAIL mon_ctrl dut%0d t=%0t: got valid/ready/ovf/sat=%b%b%b%b expected %b%b%b%b",
                   d, $time, w_tvalid[d], w_rdy[d], w_ovf[d], w_sat[d],
                   ev, er, m_ovf, (d == 1 ? m_sat4 : m_sat0));
        end
        if (ev) begin
          n_cmp++;
          if (w_tdata[d] !== (d == 1 ? f.d4 : f.d0) || w_tlast[d] !== f.last) begin
            n_err++;
            $display("FAIL mon_beat dut%0d t=%0t: got data=%h last=%b expected data=%h last=%b",
                     d, $time, w_tdata[d], w_tlast[d], (d == 1 ? f.d4 : f.d0), f.last);
          end
        end
      end
      hs  = ev && tready;
      ss0 = hs && f.s0;
      ss4 = hs && f.s4;
      if (hs) void'(q.pop_front());
      if (y_valid && er) begin
        for (int k = 0; k < N; k++) begin
          b.d0 = ref_word(longint'(y_data[k]), 0, s0);
          b.d4 = ref_word(longint'(y_data[k]), 4, s4);
          b.s0 = s0;
          b.s4 = s4;
          b.last = (k == N - 1);
          q.push_back(b);
        end
      end
      m_ovf  = (y_valid && !er) || (m_ovf && !clear_err);
      m_sat0 = ss0 || (m_sat0 && !clear_err);
      m_sat4 = ss4 || (m_sat4 && !clear_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp(input int base);
    for (int k = 0; k < N; k++) y_data[k] = DW'(base + k);
  endtask

  task automatic strobe();
    y_valid = 1'b1;
    step();
    y_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!if0.m_axis_tvalid) break;
      step();
    end
    n_cmp++;
    if (if0.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_timeout: tvalid=%b after 200 cycles, expected 0", tag, if0.m_axis_tvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({if0.m_axis_tvalid, if0.m_axis_tlast, if0.overflow_err, if0.sat_err, if4.m_axis_tvalid} !== 5'b0 ||
        if0.m_axis_tdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b l=%b o=%b s=%b data=%h, expected all 0",
               if0.m_axis_tvalid, if0.m_axis_tlast, if0.overflow_err, if0.sat_err, if0.m_axis_tdata);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (if0.capture_ready !== 1'b1 || if4.capture_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b/%b expected 1", if0.capture_ready, if4.capture_ready);
    end
  endtask

  task automatic test_ramp();
    tready = 1'b1;
    set_ramp(0);
    strobe();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (if0.m_axis_tvalid !== 1'b1 || if0.m_axis_tdata !== 32'(k) ||
          if0.m_axis_tlast !== (k == N - 1) || if0.capture_ready !== (k == N - 1)) begin
        n_err++;
        $display("FAIL ramp_beat%0d: got v=%b data=%h last=%b rdy=%b expected v=1 data=%h last=%b rdy=%b",
                 k, if0.m_axis_tvalid, if0.m_axis_tdata, if0.m_axis_tlast, if0.capture_ready,
                 32'(k), (k == N - 1), (k == N - 1));
      end
      step();
    end
    n_cmp++;
    if (if0.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ramp_end: got tvalid=%b expected 0", if0.m_axis_tvalid);
    end
  endtask

  task automatic test_saturation();
    set_ramp(0);
    y_data[0] = DW'(64'sd1 << 40);
    y_data[1] = -DW'(64'sd1 << 40);
    strobe();
    n_cmp++;
    if (if0.m_axis_tdata !== 32'h7FFFFFFF || if4.m_axis_tdata !== 32'h7FFFFFFF) begin
      n_err++;
      $display("FAIL sat_pos: got %h/%h expected 7fffffff", if0.m_axis_tdata, if4.m_axis_tdata);
    end
    step();
    n_cmp++;
    if (if0.m_axis_tdata !== 32'h80000000 || if4.m_axis_tdata !== 32'h80000000) begin
      n_err++;
      $display("FAIL sat_neg: got %h/%h expected 80000000", if0.m_axis_tdata, if4.m_axis_tdata);
    end
    wait_idle("sat");
    n_cmp++;
    if (if0.sat_err !== 1'b1 || if4.sat_err !== 1'b1) begin
      n_err++;
      $display("FAIL sat_flag: got %b/%b expected 1", if0.sat_err, if4.sat_err);
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_cmp++;
    if (if0.sat_err !== 1'b0 || if4.sat_err !== 1'b0) begin
      n_err++;
      $display("FAIL sat_clear: got %b/%b expected 0", if0.sat_err, if4.sat_err);
    end
  endtask

  task automatic test_shift();
    logic [31:0] exp4 [3];
    logic [31:0] exp0 [3];
    set_ramp(0);
    y_data[0] = DW'(24);
    y_data[1] = DW'(-24);
    y_data[2] = DW'(23);
    exp4[0] = 32'd2; exp4[1] = 32'hFFFFFFFF; exp4[2] = 32'd1;
    exp0[0] = 32'd24; exp0[1] = 32'hFFFFFFE8; exp0[2] = 32'd23;
    strobe();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (if4.m_axis_tdata !== exp4[k] || if0.m_axis_tdata !== exp0[k]) begin
        n_err++;
        $display("FAIL shift_beat%0d: got shift4=%h shift0=%h expected %h/%h",
                 k, if4.m_axis_tdata, if0.m_axis_tdata, exp4[k], exp0[k]);
      end
      step();
    end
    wait_idle("shift");
  endtask

  task automatic test_stall();
    int cnt;
    tready = 1'b1;
    set_ramp(0);
    strobe();
    for (int k = 0; k < 10; k++) step();
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (if0.m_axis_tvalid !== 1'b1 || if0.m_axis_tdata !== 32'd10 || if0.m_axis_tlast !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b data=%h last=%b expected v=1 data=0000000a last=0",
                 i, if0.m_axis_tvalid, if0.m_axis_tdata, if0.m_axis_tlast);
      end
      step();
    end
    tready = 1'b1;
    cnt = 10;
    for (int i = 0; i < 100 && if0.m_axis_tvalid; i++) begin
      if (i == 1) begin
        n_cmp++;
        if (if0.m_axis_tdata !== 32'd11) begin
          n_err++;
          $display("FAIL stall_release: got %h expected 0000000b", if0.m_axis_tdata);
        end
      end
      cnt++;
      step();
    end
    n_cmp++;
    if (cnt !== 32) begin
      n_err++;
      $display("FAIL stall_count: got %0d beats expected 32", cnt);
    end
  endtask

  task automatic test_overflow();
    tready = 1'b1;
    set_ramp(100);
    strobe();
    for (int k = 0; k < 5; k++) step();
    set_ramp(500);
    strobe();
    n_cmp++;
    if (if0.overflow_err !== 1'b1 || if4.overflow_err !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: got %b/%b expected 1", if0.overflow_err, if4.overflow_err);
    end
    for (int k = 6; k < N - 1; k++) begin
      n_cmp++;
      if (if0.m_axis_tdata !== 32'(100 + k) || if0.m_axis_tvalid !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_orig_beat%0d: got v=%b data=%h expected v=1 data=%h",
                 k, if0.m_axis_tvalid, if0.m_axis_tdata, 32'(100 + k));
      end
      step();
    end
    n_cmp++;
    if (if0.m_axis_tlast !== 1'b1 || if0.capture_ready !== 1'b1 || if0.m_axis_tdata !== 32'd131) begin
      n_err++;
      $display("FAIL ovf_last: got last=%b rdy=%b data=%h expected 1 1 00000083",
               if0.m_axis_tlast, if0.capture_ready, if0.m_axis_tdata);
    end
    set_ramp(900);
    strobe();
    n_cmp++;
    if (if0.m_axis_tvalid !== 1'b1 || if0.m_axis_tdata !== 32'd900 || if0.m_axis_tlast !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_beat0: got v=%b data=%h last=%b expected v=1 data=00000384 last=0",
               if0.m_axis_tvalid, if0.m_axis_tdata, if0.m_axis_tlast);
    end
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid();
    tready = 1'b1;
    set_ramp(0);
    strobe();
    for (int k = 0; k < 12; k++) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (if0.m_axis_tvalid !== 1'b0 || if0.overflow_err !== 1'b0 || if0.sat_err !== 1'b0 ||
        if0.m_axis_tdata !== 32'h0 || if4.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_immediate: got v=%b ovf=%b sat=%b data=%h expected 0 0 0 0",
               if0.m_axis_tvalid, if0.overflow_err, if0.sat_err, if0.m_axis_tdata);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (if0.m_axis_tvalid !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_no_beats%0d: got tvalid=%b expected 0", i, if0.m_axis_tvalid);
      end
    end
    set_ramp(40);
    strobe();
    n_cmp++;
    if (if0.m_axis_tvalid !== 1'b1 || if0.m_axis_tdata !== 32'd40) begin
      n_err++;
      $display("FAIL rstmid_restart: got v=%b data=%h expected v=1 data=00000028",
               if0.m_axis_tvalid, if0.m_axis_tdata);
    end
    wait_idle("rstmid");
  endtask

  task automatic test_random();
    longint v;
    for (int c = 0; c < 3000; c++) begin
      tready    = ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 31) == 0);
      y_valid   = ($urandom_range(0, 9) == 0);
      if (y_valid) begin
        for (int k = 0; k < N; k++) begin
          case ($urandom_range(0, 3))
            0: v = longint'($urandom_range(0, 2000)) - 1000;
            1: begin v = {$urandom, $urandom}; v = (v <<< 6) >>> 6; end
            2: v = 64'sd2147483647 + longint'($urandom_range(0, 40)) - 20;
            default: v = (longint'(1) << 35) + longint'($urandom_range(0, 40)) - 20;
          endcase
          if ($urandom_range(0, 1) == 1) v = -v - 1;
          y_data[k] = DW'(v);
        end
      end
      step();
    end
    y_valid = 1'b0;
    tready = 1'b1;
    clear_err = 1'b0;
    wait_idle("random");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) y_data[k] = '0;
    test_reset();
    test_ramp();
    test_saturation();
    test_shift();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_random();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
